// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and field constants for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, VALID, DRAIN} fetchState_e;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 6'b111111;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: instruction memory req/ack bus between fetch stage and imem
interface instr_fetch_stage_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic ack;
  modport master (output req, addr, input rdata, ack);
  modport slave (input req, addr, output rdata, ack);
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with load, wrapping increment and async reset
module fetch_pc_reg #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [ADDR_W-1:0] loadVal,
  input  logic inc,
  output logic [ADDR_W-1:0] pc
);
  // load has priority over increment; the add wraps naturally at ADDR_W bits
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else pc <= load ? loadVal : inc ? pc + ADDR_W'(PC_STEP) : pc;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: fetches one instruction per req/ack and presents it to decode
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int PC_STEP = 4
) (
  input  logic clk,
  input  logic rst,
  instr_fetch_stage_if.master imem,
  input  logic stall,
  input  logic redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0] instr_pc,
  output logic instr_valid
);
  fetchState_e state, nextState;
  logic [ADDR_W-1:0] pc, tgt, redirTgt, pcLoadVal;
  logic pcLoad, pcInc, tgtLoad, capture;
  assign redirTgt = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem.req = (state == FETCH) || (state == DRAIN);
  assign imem.addr = pc;
  assign instr_valid = state == VALID;
  assign opcode = instr_valid ? instr[DATA_W-1 -: OPCODE_W] : NOP_OPCODE;
  fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) pcReg (
    .clk(clk), .rst(rst), .load(pcLoad), .loadVal(pcLoadVal), .inc(pcInc), .pc(pc)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nextState;
  // next state and PC control; a redirect during an outstanding request waits in DRAIN for its ack
  always_comb begin
    nextState = state;
    pcLoad = 1'b0;
    pcLoadVal = redirTgt;
    pcInc = 1'b0;
    tgtLoad = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: nextState = FETCH;
      FETCH:
        if (imem.ack && redirect_en) pcLoad = 1'b1;
        else if (imem.ack) begin
          capture = 1'b1;
          pcInc = 1'b1;
          nextState = VALID;
        end else if (redirect_en) begin
          tgtLoad = 1'b1;
          nextState = DRAIN;
        end
      VALID:
        if (redirect_en) begin
          pcLoad = 1'b1;
          nextState = FETCH;
        end else if (!stall) nextState = FETCH;
      DRAIN: begin
        tgtLoad = redirect_en;
        if (imem.ack) begin
          pcLoad = 1'b1;
          pcLoadVal = redirect_en ? redirTgt : tgt;
          nextState = FETCH;
        end
      end
      default: nextState = IDLE;
    endcase
  end
  // instruction register and pending redirect target
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      instr <= '0;
      instr_pc <= '0;
      tgt <= '0;
    end else begin
      if (capture) begin
        instr <= imem.rdata;
        instr_pc <= pc;
      end
      if (tgtLoad) tgt <= redirTgt;
    end
endmodule
